// File: rtl/lcd_spi_tx_ctrl.sv
// Byte framing controller in front of the LCD left-shift register. It accepts one
// byte per handshake, then sequences the load and shift strobes, sce, D/C and the bit-valid strobe.
module lcd_spi_tx_ctrl #(
  parameter int SIZE       = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic            sck,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_dc,
  output logic            in_ready,
  output logic [SIZE-1:0] data,
  output logic            load,
  output logic            shft,
  output logic            bit_en,
  output logic            sce,
  output logic            dc,
  output logic            busy,
  output logic            done
);

  localparam int BitW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BitW-1:0] BitLast = BitW'(SIZE - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_e;

  state_e          state_q;
  logic [BitW-1:0] bitCnt_q;
  logic [BitW-1:0] bitCnt_d;
  logic [GapW-1:0] gapCnt_q;
  logic [GapW-1:0] gapCnt_d;
  logic [SIZE-1:0] data_q;
  logic            dc_q;
  logic            inReady_q;
  logic            load_q;
  logic            shft_q;
  logic            bitEn_q;
  logic            sce_q;
  logic            busy_q;
  logic            done_q;

  assign bitCnt_d = bitCnt_q + BitW'(1);
  assign gapCnt_d = gapCnt_q + GapW'(1);

  // Every output is a register set for the state being entered, so the pins are glitch-free.
  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      gapCnt_q  <= '0;
      data_q    <= '0;
      dc_q      <= 1'b0;
      inReady_q <= 1'b1;
      load_q    <= 1'b0;
      shft_q    <= 1'b0;
      bitEn_q   <= 1'b0;
      sce_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q   <= LOAD;
            data_q    <= in_data;
            dc_q      <= in_dc;
            inReady_q <= 1'b0;
            load_q    <= 1'b1;
            sce_q     <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          state_q  <= SHIFT;
          bitCnt_q <= '0;
          load_q   <= 1'b0;
          shft_q   <= (SIZE > 1);
          bitEn_q  <= 1'b1;
        end
        SHIFT: begin
          if (bitCnt_q == BitLast) begin
            state_q  <= GAP;
            gapCnt_q <= '0;
            shft_q   <= 1'b0;
            bitEn_q  <= 1'b0;
            done_q   <= (GAP_CYCLES == 1);
          end else begin
            bitCnt_q <= bitCnt_d;
            // The last bit is already at the MSB, so the shifter must not move again.
            shft_q   <= (bitCnt_d != BitLast);
          end
        end
        GAP: begin
          if (gapCnt_q == GapLast) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            sce_q     <= 1'b1;
            busy_q    <= 1'b0;
            inReady_q <= 1'b1;
          end else begin
            gapCnt_q <= gapCnt_d;
            done_q   <= (gapCnt_d == GapLast);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = inReady_q;
  assign data     = data_q;
  assign dc       = dc_q;
  assign load     = load_q;
  assign shft     = shft_q;
  assign bit_en   = bitEn_q;
  assign sce      = sce_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/lcd_spi_tx_ctrl.md
Name: lcd_spi_tx_ctrl

Overview:
- Control stage that sits directly upstream of the byte left-shift register in the static-screen LCD path.
- Accepts one byte plus a data/command flag per valid/ready handshake from the screen sequencer.
- Drives the shifter's load/shft controls, presents the byte on the shifter's data input, and frames each byte with chip-enable (sce), D/C and a bit-valid strobe.
- Reports completion with a one-cycle done pulse.

Parameters:
- SIZE, 8: bits per transfer; equals the shifter SIZE.
- GAP_CYCLES, 1: sce-low hold cycles after the last bit; minimum 1.

Ports:
- sck  input  1  system/serial clock; all logic is posedge sck.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  sequencer offers a byte.
- in_data  input  SIZE  byte to transmit.
- in_dc  input  1  1 = display data, 0 = command.
- in_ready  output  1  controller can accept a byte.
- data  output  SIZE  byte to shifter data input (registered copy of in_data).
- load  output  1  shifter load strobe.
- shft  output  1  shifter shift strobe.
- bit_en  output  1  shifter MSB is a valid bit this cycle (gates LCD clock).
- sce  output  1  LCD chip enable, active-low.
- dc  output  1  LCD D/C line, held for the whole byte.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse at end of byte.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE, data=0, dc=0, bit counter=0, gap counter=0.
  - load=shft=bit_en=done=busy=0; sce=1; in_ready=1.
- Moore FSM, states IDLE, LOAD, SHIFT, GAP. All outputs decode from state and counters only; no combinational path from in_* to any output except in_ready.
- IDLE:
  - in_ready=1, sce=1, busy=0.
  - On in_valid&in_ready at an edge, capture in_data into data and in_dc into dc, then go to LOAD.
- LOAD (1 cycle):
  - load=1, sce=0, busy=1, in_ready=0.
  - The shifter captures data at the end of this cycle.
  - Clear bit counter; next state SHIFT.
- SHIFT (SIZE cycles, counter k=0..SIZE-1):
  - bit_en=1; the shifter MSB equals data bit SIZE-1-k.
  - shft=1 for k<SIZE-1, shft=0 at k=SIZE-1, so there is no extra shift after the last bit.
  - At k=SIZE-1, go to GAP and clear the gap counter.
- GAP (GAP_CYCLES cycles):
  - sce=0, bit_en=0, shft=0.
  - done=1 only in the final GAP cycle; then go to IDLE.
- load and shft are never high in the same cycle. bit_en is never high outside SHIFT.
- Latency from an accept edge at cycle t:
  - load in cycle t+1.
  - bit_en in cycles t+2..t+1+SIZE.
  - done in cycle t+1+SIZE+GAP_CYCLES.
  - in_ready high again the following cycle.
  - Defaults: done at t+10, re-accept at t+11.
- in_valid while in_ready=0 is ignored and not queued. The sequencer holds in_valid and in_data until accepted.
- data and dc are stable from LOAD through GAP; changes on in_data/in_dc while busy have no effect.
- sce rises only on entry to IDLE. Each byte is framed separately, with minimum sce-high time of one cycle (IDLE).
- Reset mid-transfer:
  - Immediate return to reset values; sce=1 asynchronously; no done pulse.
  - The partial byte is discarded and a new accept starts from LOAD.
- Bit counter and gap counter are wide enough for SIZE-1 and GAP_CYCLES-1 with no wrap inside a state.

Test Plan:
1. Reset mid-SHIFT (after 3 bit_en cycles) -> sce=1 and load/shft/bit_en/busy=0 asynchronously; no done; next accepted byte starts cleanly with load.
2. Single command byte:
   - Stimulus: in_data=8'hA5, in_dc=0, accepted at t.
   - Response: load at t+1; bit_en t+2..t+9; serial MSB sequence through a bench shifter = 1,0,1,0,0,1,0,1; shft high t+2..t+8 only; sce low t+1..t+10; done at t+10; dc=0 throughout.
3. Back-to-back data bytes:
   - Stimulus: in_valid held high with 8'hFF then 8'h00, in_dc=1.
   - Response: second accept at t+11, its load at t+12; sce high exactly one cycle (t+11) between bytes; exactly two done pulses.
4. Busy-time disturbance: toggle in_data/in_dc and pulse in_valid during SHIFT -> transmitted bits and dc unchanged; in_ready=0; no extra transfer.
5. GAP_CYCLES=3, SIZE=8, in_data=8'h81 -> done at t+12; sce low t+1..t+12; bit pattern 1,0,0,0,0,0,0,1.
6. Invariant check over random traffic: load&shft never both 1; bit_en count per byte = SIZE; done count = accept count.
